// File: rtl/conv_rf_scheduler_if.sv
// Handshake bundle between layer control, the scheduler and the
// selector/convolution-engine pair.
interface conv_rf_scheduler_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              abort;
  logic              conv_done;
  logic [3:0]        rowNumber;
  logic [3:0]        column;
  logic              conv_start;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, conv_done,
    input  rowNumber, column, conv_start, out_we, out_addr, busy, done
  );

  modport slave (
    input  start, abort, conv_done,
    output rowNumber, column, conv_start, out_we, out_addr, busy, done
  );
endinterface

// File: rtl/conv_rf_scheduler.sv
// Steps the receptive-field selector over every output row and column half,
// pulsing the convolution engine per step and emitting a write per result set.
module conv_rf_scheduler #(
  parameter int H      = 8,
  parameter int W      = 8,
  parameter int F      = 3,
  parameter int ADDR_W = 8
) (
  input logic                clk,
  input logic                reset,
  conv_rf_scheduler_if.slave bus
);

  localparam int unsigned OUT_W    = W - F + 1;
  localparam int unsigned HALF     = OUT_W / 2;
  localparam int unsigned LAST_ROW = H - F;

  typedef enum logic [2:0] {
    IDLE, SETUP, ISSUE, WAIT, WRITE, ADVANCE, FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        row_q, row_d;
  logic              col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       addr_wide;
  logic              conv_start_q, out_we_q, busy_q, done_q;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    addr_d    = addr_q;
    addr_wide = 32'(row_q) * OUT_W + 32'(col_q) * HALF;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          row_d   = '0;
          col_d   = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Address is registered on entry so it is valid alongside out_we.
        if (bus.conv_done) begin
          addr_d  = ADDR_W'(addr_wide);
          state_d = WRITE;
        end
      end
      WRITE: state_d = ADVANCE;
      ADVANCE: begin
        if (!col_q) begin
          col_d   = 1'b1;
          state_d = SETUP;
        end else if (row_q == 4'(LAST_ROW)) begin
          state_d = FINISH;
        end else begin
          col_d   = 1'b0;
          row_d   = row_q + 4'd1;
          state_d = SETUP;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      row_d   = row_q;
      col_d   = col_q;
      addr_d  = addr_q;
    end
  end

  // Strobes are decoded from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= 1'b0;
      addr_q       <= '0;
      conv_start_q <= 1'b0;
      out_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      addr_q       <= addr_d;
      conv_start_q <= (state_d == ISSUE);
      out_we_q     <= (state_d == WRITE);
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == FINISH);
    end
  end

  assign bus.rowNumber  = row_q;
  assign bus.column     = {3'b000, col_q};
  assign bus.conv_start = conv_start_q;
  assign bus.out_we     = out_we_q;
  assign bus.out_addr   = addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_conv_rf_scheduler.sv
// Bench for conv_rf_scheduler: cycle table for the first steps, then full
// passes against a step-list model for the 8x8 and 6x6 configurations.
module tb_conv_rf_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic drv_reset, drv_start, drv_abort, drv_done, sel;

  conv_rf_scheduler_if #(.ADDR_W(8)) ifa ();
  conv_rf_scheduler_if #(.ADDR_W(8)) ifb ();

  assign ifa.start     = drv_start & ~sel;
  assign ifa.abort     = drv_abort & ~sel;
  assign ifa.conv_done = drv_done  & ~sel;
  assign ifb.start     = drv_start & sel;
  assign ifb.abort     = drv_abort & sel;
  assign ifb.conv_done = drv_done  & sel;

  conv_rf_scheduler #(.H(8), .W(8), .F(3), .ADDR_W(8)) dut_a (
    .clk(clk), .reset(drv_reset), .bus(ifa.slave)
  );
  conv_rf_scheduler #(.H(6), .W(6), .F(3), .ADDR_W(8)) dut_b (
    .clk(clk), .reset(drv_reset), .bus(ifb.slave)
  );

  logic [3:0] m_row, m_col;
  logic [7:0] m_addr;
  logic       m_cs, m_we, m_busy, m_done;

  always_comb begin
    if (sel) begin
      m_row = ifb.rowNumber; m_col = ifb.column; m_addr = ifb.out_addr;
      m_cs = ifb.conv_start; m_we = ifb.out_we; m_busy = ifb.busy; m_done = ifb.done;
    end else begin
      m_row = ifa.rowNumber; m_col = ifa.column; m_addr = ifa.out_addr;
      m_cs = ifa.conv_start; m_we = ifa.out_we; m_busy = ifa.busy; m_done = ifa.done;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_row"},  32'(m_row),  0);
    check({tag, "_col"},  32'(m_col),  0);
    check({tag, "_cs"},   32'(m_cs),   0);
    check({tag, "_we"},   32'(m_we),   0);
    check({tag, "_addr"}, 32'(m_addr), 0);
    check({tag, "_busy"}, 32'(m_busy), 0);
    check({tag, "_done"}, 32'(m_done), 0);
  endtask

  typedef struct {
    int rst, st, ab, cd;
    int row, col, cs, we, addr, busy, done;
  } vec_t;

  typedef struct {
    int row, col, addr;
  } step_t;

  function automatic int pick_latency();
    case ($urandom_range(0, 2))
      0:       return 0;
      1:       return 3;
      default: return 17;
    endcase
  endfunction

  // One full pass; optional abort in the WAIT of abort_step, or reset in the
  // WRITE of reset_step. Returns at a falling edge with the DUT idle.
  task automatic run_pass(input logic s, input bit rand_lat, input bit noise,
                          input int abort_step, input int reset_step);
    int ow, lr, hf, steps, cyc, n_cs, n_we, cnt;
    bit pending, got_real, awaiting, stable;
    logic [3:0] srow, scol;
    step_t exp_q[$];
    step_t e;
    ow = s ? 4 : 6;
    lr = s ? 3 : 5;
    hf = ow / 2;
    steps = (lr + 1) * 2;
    for (int r = 0; r <= lr; r++)
      for (int c = 0; c < 2; c++)
        exp_q.push_back('{r, c, (r * ow + c * hf) % 256});
    cyc = 0; n_cs = 0; n_we = 0; cnt = 0;
    pending = 0; got_real = 0; awaiting = 0; stable = 1;
    srow = '0; scol = '0;
    sel = s;
    drv_start = 1'b1;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("busy_after_start", 32'(m_busy), 1);
      if (m_cs) begin
        check("extra_conv_start", 32'(awaiting), 0);
        if (n_cs == 0) check("first_cs_cycle", cyc, 2);
        n_cs++;
        awaiting = 1; pending = 1; got_real = 0; stable = 1;
        srow = m_row; scol = m_col;
        cnt = rand_lat ? pick_latency() : 0;
        drv_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end else if (pending) begin
        if (m_row !== srow || m_col !== scol) stable = 0;
        if (n_cs - 1 == abort_step) begin
          drv_abort = 1'b1; drv_done = 1'b1; drv_start = 1'b0;
          @(negedge clk);
          check("abort_busy", 32'(m_busy), 0);
          check("abort_we",   32'(m_we),   0);
          check("abort_cs",   32'(m_cs),   0);
          check("abort_done", 32'(m_done), 0);
          check("abort_row_hold", 32'(m_row), 32'(srow));
          check("abort_col_hold", 32'(m_col), 32'(scol));
          drv_abort = 1'b0; drv_done = 1'b0;
          @(negedge clk);
          check("abort_no_late_done", 32'({m_done, m_busy, m_we}), 0);
          return;
        end
        if (cnt == 0) begin
          drv_done = 1'b1; pending = 0; got_real = 1;
        end else begin
          cnt--; drv_done = 1'b0;
        end
      end else begin
        drv_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (m_we) begin
        check("early_write", 32'(got_real), 1);
        check("wait_stable", 32'(stable), 1);
        check("write_in_range", 32'(n_we < steps), 1);
        if (n_we < steps) begin
          e = exp_q[n_we];
          check($sformatf("step%0d_addr", n_we), 32'(m_addr), e.addr);
          check($sformatf("step%0d_row", n_we),  32'(m_row),  e.row);
          check($sformatf("step%0d_col", n_we),  32'(m_col),  e.col);
        end
        n_we++; awaiting = 0; got_real = 0;
        if (n_we - 1 == reset_step) begin
          drv_reset = 1'b1; drv_start = 1'b0; drv_done = 1'b0;
          @(negedge clk);
          check_idle_zero("midreset");
          drv_start = 1'b1;
          repeat (3) begin
            @(negedge clk);
            check("reset_hold_busy", 32'({m_busy, m_cs, m_we, m_done}), 0);
          end
          drv_reset = 1'b0; drv_start = 1'b0;
          @(negedge clk);
          check("post_reset_idle", 32'(m_busy), 0);
          return;
        end
      end
      if (m_done) begin
        check("pass_cs_count", n_cs, steps);
        check("pass_we_count", n_we, steps);
        drv_start = 1'b0; drv_done = 1'b0;
        @(negedge clk);
        check("post_done_busy", 32'(m_busy), 0);
        check("done_single",    32'(m_done), 0);
        return;
      end
      drv_start = (noise && m_busy) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
    end
    check("pass_timeout", 1, 0);
    drv_start = 1'b0; drv_done = 1'b0; drv_abort = 1'b0;
  endtask

  vec_t tbl[22];

  initial begin
    tbl[0]  = '{1,0,0,0, 0,0,0,0,0,0,0};
    tbl[1]  = '{1,1,0,0, 0,0,0,0,0,0,0};
    tbl[2]  = '{0,0,0,0, 0,0,0,0,0,0,0};
    tbl[3]  = '{0,0,1,0, 0,0,0,0,0,0,0};
    tbl[4]  = '{0,0,0,1, 0,0,0,0,0,0,0};
    tbl[5]  = '{0,1,0,0, 0,0,0,0,0,1,0};
    tbl[6]  = '{0,0,0,1, 0,0,1,0,0,1,0};
    tbl[7]  = '{0,0,0,0, 0,0,0,0,0,1,0};
    tbl[8]  = '{0,0,0,0, 0,0,0,0,0,1,0};
    tbl[9]  = '{0,0,0,1, 0,0,0,1,0,1,0};
    tbl[10] = '{0,0,0,0, 0,0,0,0,0,1,0};
    tbl[11] = '{0,0,0,0, 0,1,0,0,0,1,0};
    tbl[12] = '{0,1,0,0, 0,1,1,0,0,1,0};
    tbl[13] = '{0,0,0,0, 0,1,0,0,0,1,0};
    tbl[14] = '{0,0,0,1, 0,1,0,1,3,1,0};
    tbl[15] = '{0,0,0,0, 0,1,0,0,3,1,0};
    tbl[16] = '{0,0,0,0, 1,0,0,0,3,1,0};
    tbl[17] = '{0,0,0,0, 1,0,1,0,3,1,0};
    tbl[18] = '{0,0,1,1, 1,0,0,0,3,0,0};
    tbl[19] = '{0,0,0,0, 1,0,0,0,3,0,0};
    tbl[20] = '{0,1,0,0, 0,0,0,0,3,1,0};
    tbl[21] = '{1,0,0,0, 0,0,0,0,0,0,0};

    sel = 1'b0;
    drv_reset = 1'b1; drv_start = 1'b0; drv_abort = 1'b0; drv_done = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");

    for (int i = 0; i < 22; i++) begin
      drv_reset = (tbl[i].rst != 0);
      drv_start = (tbl[i].st  != 0);
      drv_abort = (tbl[i].ab  != 0);
      drv_done  = (tbl[i].cd  != 0);
      @(negedge clk);
      check($sformatf("vec%0d_row", i),  32'(m_row),  tbl[i].row);
      check($sformatf("vec%0d_col", i),  32'(m_col),  tbl[i].col);
      check($sformatf("vec%0d_cs", i),   32'(m_cs),   tbl[i].cs);
      check($sformatf("vec%0d_we", i),   32'(m_we),   tbl[i].we);
      check($sformatf("vec%0d_addr", i), 32'(m_addr), tbl[i].addr);
      check($sformatf("vec%0d_busy", i), 32'(m_busy), tbl[i].busy);
      check($sformatf("vec%0d_done", i), 32'(m_done), tbl[i].done);
    end
    drv_reset = 1'b0; drv_start = 1'b0; drv_abort = 1'b0; drv_done = 1'b0;
    @(negedge clk);

    run_pass(1'b0, 1'b0, 1'b0, -1, -1);
    repeat (3) run_pass(1'b0, 1'b1, 1'b0, -1, -1);
    repeat (2) run_pass(1'b0, 1'b1, 1'b1, -1, -1);
    run_pass(1'b0, 1'b0, 1'b0, 4, -1);
    run_pass(1'b0, 1'b0, 1'b0, -1, -1);
    run_pass(1'b0, 1'b1, 1'b0, -1, 6);
    run_pass(1'b0, 1'b0, 1'b0, -1, -1);
    run_pass(1'b1, 1'b0, 1'b0, -1, -1);
    run_pass(1'b1, 1'b1, 1'b1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_rf_scheduler.md
Name: conv_rf_scheduler

Overview:
- Sequences a 3x3 convolution pass over one D×H×W image.
- Steps the combinational receptive-field selector through every output row and both column halves, pulsing the convolution engine once per step and waiting for its completion.
- After each completion, issues a write strobe and base address for the (W-F+1)/2 results of that step.
- Sits between the top-level layer control (start/done) and the selector + convolution engine pair.

Parameters:
- H, 8, image height
- W, 8, image width
- F, 3, filter size
- ADDR_W, 8, width of the output-buffer base address

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a full image pass; sampled only in IDLE
- abort  input  1  cancels the pass in progress; synchronous
- conv_done  input  1  convolution engine finished current receptive-field set; sampled only in WAIT
- rowNumber  output  4  row index driven to selector
- column  output  4  column-half select to selector (0 = left half, 1 = right half)
- conv_start  output  1  one-cycle pulse to the convolution engine
- out_we  output  1  one-cycle write strobe for results of the current step
- out_addr  output  ADDR_W  base address of current step's results
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the final write

Behaviour:
- Reset values, applied synchronously whenever reset=1 (including mid-pass): state=IDLE, rowNumber=0, column=0, conv_start=0, out_we=0, out_addr=0, busy=0, done=0.
- Derived constants:
  - OUT_W = W-F+1.
  - HALF = OUT_W/2.
  - LAST_ROW = H-F.
  - Steps per pass = (LAST_ROW+1)*2.
- All outputs are registered.
- States: IDLE, SETUP, ISSUE, WAIT, WRITE, ADVANCE, FINISH.
- IDLE:
  - On start=1: rowNumber<=0, column<=0; go to SETUP.
  - Otherwise stay in IDLE.
- SETUP:
  - One cycle for the selector output to settle and be captured by the engine input registers.
  - Go to ISSUE.
- ISSUE:
  - conv_start=1 for exactly this cycle.
  - Go to WAIT.
- WAIT:
  - conv_start=0.
  - Stay until conv_done=1, then go to WRITE.
  - conv_done in any other state is ignored.
- WRITE:
  - out_we=1 for exactly this cycle.
  - out_addr=rowNumber*OUT_W + column*HALF, truncated to ADDR_W bits.
  - Go to ADVANCE.
- ADVANCE:
  - If column=0: column<=1, go to SETUP.
  - Else if rowNumber=LAST_ROW: go to FINISH.
  - Else: column<=0, rowNumber<=rowNumber+1, go to SETUP.
- FINISH:
  - done=1 for one cycle.
  - rowNumber and column stay at their last values.
  - Go to IDLE; busy=0 from that cycle.
- rowNumber and column are stable from SETUP through WRITE of each step.
- Minimum latency per step with conv_done returned the first WAIT cycle: 5 cycles (SETUP, ISSUE, WAIT, WRITE, ADVANCE).
- Timing of the start/done pair:
  - start sampled at edge k.
  - First conv_start is visible in cycle k+2.
  - done pulse follows the last ADVANCE by one cycle.
- start while busy=1 is ignored; no queuing.
- abort=1 in any non-IDLE state:
  - Next state IDLE; conv_start, out_we and done forced 0 that edge.
  - rowNumber, column and out_addr hold their values.
  - No done pulse.
  - abort in IDLE has no effect.
- Priority: reset > abort > normal transitions.
- A conv_done that arrives in the same cycle as abort is dropped.

Test Plan:
- Full pass, H=8 W=8 F=3, conv_done returned 1 cycle after each conv_start:
  - Exactly 12 conv_start pulses and 12 out_we pulses.
  - out_addr sequence 0,3,6,9,...,30,33.
  - (rowNumber,column) sequence (0,0),(0,1),...,(5,1).
  - One done pulse, then busy=0.
- Variable engine latency (conv_done delayed 0, 3 and 17 WAIT cycles, randomized):
  - out_addr sequence identical to the full-pass case.
  - rowNumber/column stable throughout each WAIT.
  - No extra conv_start.
- start pulsed while busy, plus spurious conv_done during SETUP/ISSUE/WRITE:
  - Ignored; pass completes with 12 writes.
  - No early WRITE.
- abort during WAIT of step 5:
  - Next cycle state=IDLE, busy=0, no done, no out_we.
  - A subsequent start restarts from rowNumber=0, column=0 and completes normally.
- reset asserted mid-pass (during WRITE):
  - Next cycle all outputs at reset values, out_we=0.
  - reset held while start=1 produces no activity.
- Parameter variant H=6 W=6 F=3 (OUT_W=4, HALF=2):
  - 8 steps.
  - out_addr 0,2,4,6,8,10,12,14.
  - LAST_ROW=3.
